// File: rtl/bell_sequencer.sv
// Buzzer sequencer: arbitrates the daily alarm against the hourly chime, generates
// the beep cadence and runs the snooze / stop / ring-timeout state machine.
`timescale 1ns/1ps
module bell_sequencer #(
    parameter int unsigned BEEP_CYCLES     = 12500000,
    parameter int unsigned CHIME_BEEPS     = 3,
    parameter int unsigned ALARM_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S        = 300,
    parameter int unsigned MAX_SNOOZE      = 3
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [7:0] hour_time,
    input  logic [7:0] minute_time,
    input  logic [7:0] second_time,
    input  logic [7:0] alarm_hour_time,
    input  logic [7:0] alarm_minute_time,
    input  logic [7:0] alarm_second_time,
    input  logic       alarm_en,
    input  logic       chime_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       bell_out,
    output logic       alarm_active,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHIME  = 2'd1,
        ALARM  = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    localparam logic [23:0] PHASE_LAST   = 24'(BEEP_CYCLES - 1);
    localparam logic [3:0]  CHIME_INIT   = 4'(CHIME_BEEPS);
    localparam logic [7:0]  TIMEOUT_INIT = 8'(ALARM_TIMEOUT_S);
    localparam logic [9:0]  SNOOZE_INIT  = 10'(SNOOZE_S);
    localparam logic [1:0]  SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    state_t      state;
    logic [23:0] phase_cnt;
    logic [3:0]  beep_cnt;
    logic [7:0]  timeout_cnt;
    logic [9:0]  snooze_cnt;

    logic alarm_hit;
    logic chime_hit;
    logic phase_wrap;
    logic alarm_quit;

    assign alarm_hit  = tick_1hz & alarm_en
                      & (hour_time   == alarm_hour_time)
                      & (minute_time == alarm_minute_time)
                      & (second_time == alarm_second_time);
    assign chime_hit  = tick_1hz & chime_en
                      & (minute_time == 8'd0)
                      & (second_time == 8'd0);
    assign phase_wrap = (phase_cnt == PHASE_LAST);

    // A snooze press with no snoozes left is treated exactly like stop.
    assign alarm_quit = stop_btn | ~alarm_en
                      | (snooze_btn & (snooze_count == SNOOZE_LIMIT));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bell_out     <= 1'b0;
            alarm_active <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= 2'd0;
            phase_cnt    <= 24'd0;
            beep_cnt     <= 4'd0;
            timeout_cnt  <= 8'd0;
            snooze_cnt   <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    bell_out     <= 1'b0;
                    alarm_active <= 1'b0;
                    snoozing     <= 1'b0;
                    phase_cnt    <= 24'd0;
                    if (alarm_hit) begin
                        state        <= ALARM;
                        alarm_active <= 1'b1;
                        bell_out     <= 1'b1;
                        snooze_count <= 2'd0;
                        timeout_cnt  <= TIMEOUT_INIT;
                    end else if (chime_hit) begin
                        state    <= CHIME;
                        bell_out <= 1'b1;
                        beep_cnt <= CHIME_INIT;
                    end
                end

                CHIME: begin
                    if (stop_btn) begin
                        state     <= IDLE;
                        bell_out  <= 1'b0;
                        phase_cnt <= 24'd0;
                        beep_cnt  <= 4'd0;
                    end else if (alarm_hit) begin
                        state        <= ALARM;
                        alarm_active <= 1'b1;
                        bell_out     <= 1'b1;
                        phase_cnt    <= 24'd0;
                        beep_cnt     <= 4'd0;
                        snooze_count <= 2'd0;
                        timeout_cnt  <= TIMEOUT_INIT;
                    end else if (phase_wrap) begin
                        phase_cnt <= 24'd0;
                        // beep_cnt counts on-periods still owed; it drops as each off-period ends.
                        if (!bell_out && (beep_cnt <= 4'd1)) begin
                            state    <= IDLE;
                            bell_out <= 1'b0;
                            beep_cnt <= 4'd0;
                        end else begin
                            bell_out <= ~bell_out;
                            if (!bell_out) begin
                                beep_cnt <= beep_cnt - 4'd1;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end

                ALARM: begin
                    if (alarm_quit) begin
                        state        <= IDLE;
                        alarm_active <= 1'b0;
                        bell_out     <= 1'b0;
                        phase_cnt    <= 24'd0;
                        snooze_count <= 2'd0;
                        timeout_cnt  <= 8'd0;
                    end else if (snooze_btn) begin
                        state        <= SNOOZE;
                        alarm_active <= 1'b0;
                        snoozing     <= 1'b1;
                        bell_out     <= 1'b0;
                        phase_cnt    <= 24'd0;
                        snooze_count <= snooze_count + 2'd1;
                        snooze_cnt   <= SNOOZE_INIT;
                    end else if (tick_1hz && (timeout_cnt <= 8'd1)) begin
                        state        <= IDLE;
                        alarm_active <= 1'b0;
                        bell_out     <= 1'b0;
                        phase_cnt    <= 24'd0;
                        snooze_count <= 2'd0;
                        timeout_cnt  <= 8'd0;
                    end else begin
                        if (tick_1hz) begin
                            timeout_cnt <= timeout_cnt - 8'd1;
                        end
                        if (phase_wrap) begin
                            phase_cnt <= 24'd0;
                            bell_out  <= ~bell_out;
                        end else begin
                            phase_cnt <= phase_cnt + 24'd1;
                        end
                    end
                end

                SNOOZE: begin
                    bell_out  <= 1'b0;
                    phase_cnt <= 24'd0;
                    if (stop_btn || !alarm_en) begin
                        state        <= IDLE;
                        snoozing     <= 1'b0;
                        snooze_count <= 2'd0;
                        snooze_cnt   <= 10'd0;
                    end else if (tick_1hz && (snooze_cnt <= 10'd1)) begin
                        // Snooze expiry resumes ringing with a fresh cadence and a full timeout.
                        state        <= ALARM;
                        snoozing     <= 1'b0;
                        alarm_active <= 1'b1;
                        bell_out     <= 1'b1;
                        snooze_cnt   <= 10'd0;
                        timeout_cnt  <= TIMEOUT_INIT;
                    end else if (tick_1hz) begin
                        snooze_cnt <= snooze_cnt - 10'd1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bell_out     <= 1'b0;
                    alarm_active <= 1'b0;
                    snoozing     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bell_sequencer.sv
// Directed bench for bell_sequencer: expected outputs are queued as stimulus is
// applied and compared cycle by cycle as the design produces them.
`timescale 1ns/1ps
module tb_bell_sequencer;

    localparam int BEEP    = 4;
    localparam int NBEEPS  = 3;
    localparam int TIMEOUT = 4;
    localparam int SNZ     = 5;
    localparam int MAXSNZ  = 3;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic [7:0] hour_time, minute_time, second_time;
    logic [7:0] alarm_hour_time, alarm_minute_time, alarm_second_time;
    logic       alarm_en, chime_en, snooze_btn, stop_btn;
    logic       bell_out, alarm_active, snoozing;
    logic [1:0] snooze_count;

    typedef struct {
        string      tag;
        logic [4:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_50M = ~clk_50M;

    bell_sequencer #(
        .BEEP_CYCLES    (BEEP),
        .CHIME_BEEPS    (NBEEPS),
        .ALARM_TIMEOUT_S(TIMEOUT),
        .SNOOZE_S       (SNZ),
        .MAX_SNOOZE     (MAXSNZ)
    ) dut (
        .clk_50M          (clk_50M),
        .rst_n            (rst_n),
        .tick_1hz         (tick_1hz),
        .hour_time        (hour_time),
        .minute_time      (minute_time),
        .second_time      (second_time),
        .alarm_hour_time  (alarm_hour_time),
        .alarm_minute_time(alarm_minute_time),
        .alarm_second_time(alarm_second_time),
        .alarm_en         (alarm_en),
        .chime_en         (chime_en),
        .snooze_btn       (snooze_btn),
        .stop_btn         (stop_btn),
        .bell_out         (bell_out),
        .alarm_active     (alarm_active),
        .snoozing         (snoozing),
        .snooze_count     (snooze_count)
    );

    task automatic cyc();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hour_time   = h;
        minute_time = m;
        second_time = s;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic push(input string tag, input logic b, input logic a, input logic s,
                        input logic [1:0] c);
        exp_t e;
        e.tag = tag;
        e.val = {b, a, s, c};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [4:0] got;
        got = {bell_out, alarm_active, snoozing, snooze_count};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%b expected=<queued value>", got);
        end else begin
            e = sb.pop_front();
            assert (got === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b (bell,active,snoozing,count)",
                       e.tag, got, e.val);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic b, input logic a, input logic s,
                              input logic [1:0] c);
        push(tag, b, a, s, c);
        pop_check();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b1;
        tick_1hz    = 1'b0;
        alarm_en    = 1'b0;
        chime_en    = 1'b0;
        snooze_btn  = 1'b0;
        stop_btn    = 1'b0;
        set_time(8'd9, 8'd59, 8'd58);
        alarm_hour_time   = 8'd7;
        alarm_minute_time = 8'd0;
        alarm_second_time = 8'd0;
        #2 rst_n = 1'b0;
        #10;
        expect_now("reset_state", 0, 0, 0, 2'd0);
        @(negedge clk_50M);
        rst_n = 1'b1;
        cyc();
        expect_now("after_release", 0, 0, 0, 2'd0);

        // Hourly chime: 1111 0000 x3 then silence.
        chime_en = 1'b1;
        set_time(8'd10, 8'd0, 8'd0);
        for (int r = 0; r < NBEEPS; r++)
            for (int p = 0; p < 2 * BEEP; p++)
                push("chime_bell", (p < BEEP), 0, 0, 2'd0);
        tick();
        for (int i = 0; i < 2 * NBEEPS * BEEP; i++) begin
            pop_check();
            cyc();
        end
        for (int i = 0; i < 6; i++) begin
            expect_now("chime_done", 0, 0, 0, 2'd0);
            cyc();
        end

        set_time(8'd13, 8'd0, 8'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            expect_now("no_chime_0001", 0, 0, 0, 2'd0);
            cyc();
        end

        // Alarm and chime both hit on the same tick: alarm wins.
        alarm_en = 1'b1;
        set_time(8'd7, 8'd0, 8'd0);
        tick();
        expect_now("priority_alarm", 1, 1, 0, 2'd0);
        set_time(8'd7, 8'd0, 8'd1);
        stop_btn = 1'b1;
        cyc();
        stop_btn = 1'b0;
        expect_now("stop_alarm", 0, 0, 0, 2'd0);

        // Alarm preempts a running chime with a restarted cadence.
        set_time(8'd10, 8'd0, 8'd0);
        for (int p = 0; p < 6; p++) push("chime_pre", (p < BEEP), 0, 0, 2'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            pop_check();
            cyc();
        end
        set_time(8'd7, 8'd0, 8'd0);
        for (int p = 0; p < 5; p++) push("preempt_cadence", (p < BEEP), 1, 0, 2'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            pop_check();
            cyc();
        end

        // Snooze up to the limit; one more press stops the alarm.
        set_time(8'd7, 8'd0, 8'd1);
        for (int k = 1; k <= MAXSNZ; k++) begin
            snooze_btn = 1'b1;
            cyc();
            snooze_btn = 1'b0;
            expect_now("snooze_enter", 0, 0, 1, 2'(k));
            for (int t = 1; t <= SNZ; t++) begin
                tick();
                if (t < SNZ) expect_now("snooze_wait", 0, 0, 1, 2'(k));
                else         expect_now("snooze_expire", 1, 1, 0, 2'(k));
            end
        end
        snooze_btn = 1'b1;
        cyc();
        snooze_btn = 1'b0;
        expect_now("snooze_over_limit", 0, 0, 0, 2'd0);

        // Ring timeout with back-to-back ticks.
        chime_en = 1'b0;
        set_time(8'd7, 8'd0, 8'd0);
        tick();
        expect_now("timeout_entry", 1, 1, 0, 2'd0);
        set_time(8'd7, 8'd0, 8'd1);
        for (int t = 1; t <= TIMEOUT; t++) begin
            tick();
            if (t < TIMEOUT) expect_now("timeout_wait", 1, 1, 0, 2'd0);
            else             expect_now("timeout_idle", 0, 0, 0, 2'd0);
        end

        // Stop and snooze pressed together: stop wins.
        set_time(8'd7, 8'd0, 8'd0);
        tick();
        expect_now("both_entry", 1, 1, 0, 2'd0);
        set_time(8'd7, 8'd0, 8'd1);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        cyc();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        expect_now("stop_and_snooze", 0, 0, 0, 2'd0);

        // Disarming while ringing returns to idle.
        set_time(8'd7, 8'd0, 8'd0);
        tick();
        expect_now("en_entry", 1, 1, 0, 2'd0);
        set_time(8'd7, 8'd0, 8'd1);
        alarm_en = 1'b0;
        cyc();
        alarm_en = 1'b1;
        expect_now("alarm_en_drop", 0, 0, 0, 2'd0);

        // Asynchronous reset in the middle of a resumed alarm.
        set_time(8'd7, 8'd0, 8'd0);
        tick();
        expect_now("rst_entry", 1, 1, 0, 2'd0);
        set_time(8'd7, 8'd0, 8'd1);
        snooze_btn = 1'b1;
        cyc();
        snooze_btn = 1'b0;
        for (int t = 0; t < SNZ; t++) tick();
        expect_now("rst_resumed", 1, 1, 0, 2'd1);
        @(posedge clk_50M);
        #3 rst_n = 1'b0;
        #1;
        expect_now("async_reset", 0, 0, 0, 2'd0);
        @(negedge clk_50M);
        rst_n = 1'b1;
        cyc();
        expect_now("post_reset", 0, 0, 0, 2'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_now("post_reset_quiet", 0, 0, 0, 2'd0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bell_sequencer.md
Name: bell_sequencer

Overview:
- Controls the clock's buzzer.
- Arbitrates two ring requesters: the daily alarm (high priority) and the hourly chime (low priority).
- Generates the beep cadence on bell_out and handles the snooze/stop buttons, snooze countdown and ring timeout.
- Sits between the timekeeping counters and the buzzer pin, and replaces direct time-compare bell logic.

Parameters:
- BEEP_CYCLES, 12500000, clk_50M cycles per beep half-period (on or off); 0.25 s at 50 MHz.
- CHIME_BEEPS, 3, number of beeps per hourly chime (1..15).
- ALARM_TIMEOUT_S, 60, seconds of ringing before auto-stop (1..255).
- SNOOZE_S, 300, snooze interval in seconds (1..1023).
- MAX_SNOOZE, 3, snoozes allowed per alarm event; a further snooze press acts as stop (1..3).

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-cycle strobe, asserted on the first cycle the new time values are valid.
- hour_time  in  8  current hour, binary 0..23.
- minute_time  in  8  current minute, binary 0..59.
- second_time  in  8  current second, binary 0..59.
- alarm_hour_time  in  8  alarm hour, binary.
- alarm_minute_time  in  8  alarm minute, binary.
- alarm_second_time  in  8  alarm second, binary.
- alarm_en  in  1  alarm armed (level).
- chime_en  in  1  hourly chime enabled (level).
- snooze_btn  in  1  debounced single-cycle pulse.
- stop_btn  in  1  debounced single-cycle pulse.
- bell_out  out  1  buzzer drive.
- alarm_active  out  1  high in ALARM.
- snoozing  out  1  high in SNOOZE.
- snooze_count  out  2  snoozes used in the current alarm event.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; all counters 0.
- Triggers are evaluated only in cycles with tick_1hz=1, using the time inputs of that cycle.
  - alarm_hit = alarm_en & hour/minute/second all equal to the alarm fields.
  - chime_hit = chime_en & minute_time==0 & second_time==0.
- States: IDLE, CHIME, ALARM, SNOOZE.
- Entry rule: bell_out goes 1 on the cycle after any transition into CHIME or ALARM. The beep phase counter clears on entry.
- Cadence: bell_out toggles every BEEP_CYCLES cycles (50% duty).
- IDLE:
  - alarm_hit -> ALARM, snooze_count=0, timeout counter=ALARM_TIMEOUT_S.
  - Otherwise, chime_hit -> CHIME, beep counter=CHIME_BEEPS.
  - If both hit in the same cycle, ALARM wins.
- CHIME:
  - After CHIME_BEEPS on-periods and the trailing off-period -> IDLE. Total 2*CHIME_BEEPS*BEEP_CYCLES cycles.
  - alarm_hit preempts -> ALARM, with fresh cadence.
  - stop_btn -> IDLE; bell_out=0 next cycle.
  - snooze_btn is ignored.
- ALARM:
  - Timeout counter decrements on each tick_1hz; reaching 0 -> IDLE.
  - stop_btn -> IDLE and clears snooze_count.
  - snooze_btn with snooze_count<MAX_SNOOZE -> SNOOZE, snooze_count+1, snooze counter=SNOOZE_S.
  - snooze_btn with snooze_count==MAX_SNOOZE behaves as stop.
  - alarm_en=0 -> IDLE.
  - chime_hit is ignored.
  - Same-cycle precedence: stop > alarm_en drop > snooze > timeout.
- SNOOZE:
  - bell_out=0.
  - Snooze counter decrements on each tick_1hz; reaching 0 -> ALARM, with timeout reloaded and snooze_count kept.
  - stop_btn or alarm_en=0 -> IDLE.
  - chime_hit and alarm_hit are ignored.
- When bell_out is not in CHIME or ALARM, it is 0 within one cycle of leaving those states.
- Counters:
  - Phase counter: 24 bits, wraps at BEEP_CYCLES-1.
  - Timeout counter: 8 bits.
  - Snooze counter: 10 bits.
  - No counter underflows; the transition at 0 takes precedence.
- alarm_active and snoozing are registered and decode the state directly.

Test Plan:
- Chime: BEEP_CYCLES=4, CHIME_BEEPS=3, chime_en=1, tick with 10:00:00 -> bell_out pattern 1111 0000 ×3 starting the cycle after the tick, then IDLE. 13:00:01 -> no ring.
- Priority: alarm set 07:00:00 with alarm_en=1 and chime_en=1, tick at 07:00:00 -> alarm_active=1, not CHIME.
- Preemption: mid-chime, alarm_hit -> ALARM next cycle with cadence restarted at 1.
- Snooze: press snooze in ALARM -> snoozing=1, snooze_count=1, bell_out=0. After SNOOZE_S=5 ticks -> ALARM. Repeat to MAX_SNOOZE=3; a 4th press -> IDLE and snooze_count=0.
- Timeout: ALARM_TIMEOUT_S=4, no buttons -> IDLE after the 4th tick. Stop and snooze in the same cycle -> IDLE.
- Reset: assert rst_n=0 mid-ALARM, asynchronously and not on a clock edge -> bell_out, alarm_active, snoozing and snooze_count all 0 immediately. Release -> IDLE with no ring until the next trigger.
